// File: rtl/ds2411_pkg.sv
// ds2411_pkg: shared state encoding, command codes and CRC constant for the DS2411 emulator.
package ds2411_pkg;
  typedef enum logic [2:0] {IDLE, PRES_WAIT, PRES_DRIVE, CMD_RX, ROM_TX, MUTE} state_t;
  localparam logic [7:0] CMD_READ_ROM        = 8'h33;
  localparam logic [7:0] CMD_READ_ROM_LEGACY = 8'h0F;
  // x^8+x^5+x^4+1 in bit-reversed form, for LSB-first shifting
  localparam logic [7:0] CRC8_POLY_REFL      = 8'h8C;
  function automatic logic is_rom_cmd(input logic [7:0] c);
    return (c == CMD_READ_ROM) || (c == CMD_READ_ROM_LEGACY);
  endfunction
endpackage

// File: rtl/onewire_crc8.sv
// onewire_crc8: bit-serial Dallas CRC-8, LSB first, init 0.
module onewire_crc8
  import ds2411_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);
  logic [7:0] r_crc;
  logic       w_fb;
  assign w_fb  = r_crc[0] ^ i_bit;
  assign o_crc = r_crc;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)  r_crc <= '0;
    else if (i_clr) r_crc <= '0;
    else if (i_en)  r_crc <= {1'b0, r_crc[7:1]} ^ (w_fb ? CRC8_POLY_REFL : 8'h00);
endmodule

// File: rtl/ds2411_emulator.sv
// ds2411_emulator: 1-Wire slave answering reset/presence and Read ROM with a 64-bit ID.
// Define DS2411_CRC_GEN_EN to replace rom_id[63:56] with a locally computed CRC-8.
module ds2411_emulator
  import ds2411_pkg::*;
#(
  parameter int CLK_MHZ       = 100,
  parameter int RESET_US      = 480,
  parameter int PRES_DELAY_US = 30,
  parameter int PRES_US       = 120,
  parameter int SAMPLE_US     = 30,
  parameter int HOLD_US       = 30
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_dq_in,
  output logic        o_dq_pd,
  input  logic [63:0] i_rom_id,
  output logic        o_busy,
  output logic        o_rom_done,
  output logic        o_cmd_err,
  output logic [7:0]  o_last_cmd
);
  localparam logic [19:0] RST_LAST  = 20'(RESET_US * CLK_MHZ - 1);
  localparam logic [19:0] PD_LAST   = 20'(PRES_DELAY_US * CLK_MHZ - 1);
  localparam logic [19:0] PRES_LAST = 20'(PRES_US * CLK_MHZ - 1);
  localparam logic [19:0] SMP_LAST  = 20'(SAMPLE_US * CLK_MHZ - 1);
  localparam logic [19:0] HOLD_LAST = 20'(HOLD_US * CLK_MHZ - 1);

  logic [1:0]  r_sync, r_mask;
  logic        r_dq_d, r_rst_seen, r_slot;
  logic [19:0] r_low, r_tmr;
  logic [6:0]  r_idx, r_cmd;
  logic [63:0] r_rom;
  state_t      r_state;
  logic        w_dq, w_masked, w_fall, w_rise, w_low, w_rst_hit, w_tx_bit;
  logic [7:0]  w_new_cmd;

  assign w_dq      = r_sync[1];
  // our own pull-down and the synchroniser tail after release must not look like master activity
  assign w_masked  = o_dq_pd | (r_mask != 2'd0);
  assign w_fall    = r_dq_d & ~w_dq & ~w_masked;
  assign w_rise    = w_dq & ~r_dq_d;
  assign w_low     = ~w_dq & ~w_masked;
  assign w_rst_hit = w_low & (r_low >= RST_LAST);
  assign w_new_cmd = {w_dq, r_cmd};

`ifdef DS2411_CRC_GEN_EN
  logic [7:0] w_crc;
  onewire_crc8 u_crc (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (r_state == PRES_DRIVE),
    .i_en   (r_state == ROM_TX && w_fall && r_idx < 7'd56),
    .i_bit  (r_rom[r_idx[5:0]]),
    .o_crc  (w_crc)
  );
  assign w_tx_bit = (r_idx >= 7'd56) ? w_crc[r_idx[2:0]] : r_rom[r_idx[5:0]];
`else
  assign w_tx_bit = r_rom[r_idx[5:0]];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sync <= 2'b11;
      r_dq_d <= 1'b1;
      r_mask <= '0;
      r_low  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_dq_in};
      r_dq_d <= w_dq;
      r_mask <= o_dq_pd ? 2'd3 : (r_mask != 2'd0 ? r_mask - 2'd1 : 2'd0);
      r_low  <= w_low ? r_low + {19'd0, r_low != '1} : '0;
    end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_rst_seen <= 1'b0;
      r_slot     <= 1'b0;
      r_tmr      <= '0;
      r_idx      <= '0;
      r_cmd      <= '0;
      r_rom      <= '0;
      o_dq_pd    <= 1'b0;
      o_busy     <= 1'b0;
      o_rom_done <= 1'b0;
      o_cmd_err  <= 1'b0;
      o_last_cmd <= '0;
    end else begin
      o_rom_done <= 1'b0;
      o_cmd_err  <= 1'b0;
      if (w_rst_hit) begin
        r_rst_seen <= 1'b1;
        r_state    <= IDLE;
        r_slot     <= 1'b0;
        o_dq_pd    <= 1'b0;
        o_busy     <= 1'b0;
      end else if (r_rst_seen && w_rise) begin
        r_rst_seen <= 1'b0;
        r_state    <= PRES_WAIT;
        r_tmr      <= '0;
        o_busy     <= 1'b1;
      end else begin
        case (r_state)
          PRES_WAIT:
            if (r_tmr == PD_LAST) begin
              r_state <= PRES_DRIVE;
              r_tmr   <= '0;
              r_rom   <= i_rom_id;
              o_dq_pd <= 1'b1;
            end else r_tmr <= r_tmr + 20'd1;
          PRES_DRIVE:
            if (r_tmr == PRES_LAST) begin
              r_state <= CMD_RX;
              r_idx   <= '0;
              r_slot  <= 1'b0;
              o_dq_pd <= 1'b0;
            end else r_tmr <= r_tmr + 20'd1;
          CMD_RX:
            if (w_fall) begin
              r_slot <= 1'b1;
              r_tmr  <= '0;
            end else if (r_slot) begin
              if (r_tmr == SMP_LAST) begin
                r_slot <= 1'b0;
                r_cmd  <= {w_dq, r_cmd[6:1]};
                r_idx  <= r_idx + 7'd1;
                if (r_idx == 7'd7) begin
                  o_last_cmd <= w_new_cmd;
                  r_idx      <= '0;
                  r_state    <= is_rom_cmd(w_new_cmd) ? ROM_TX : MUTE;
                  o_cmd_err  <= ~is_rom_cmd(w_new_cmd);
                  o_busy     <= is_rom_cmd(w_new_cmd);
                end
              end else r_tmr <= r_tmr + 20'd1;
            end
          ROM_TX:
            if (w_fall && r_idx != 7'd64) begin
              r_slot  <= 1'b1;
              r_tmr   <= '0;
              r_idx   <= r_idx + 7'd1;
              o_dq_pd <= ~w_tx_bit;
            end else if (r_slot) begin
              if (r_tmr == HOLD_LAST) begin
                r_slot  <= 1'b0;
                o_dq_pd <= 1'b0;
                if (r_idx == 7'd64) begin
                  o_rom_done <= 1'b1;
                  o_busy     <= 1'b0;
                  r_state    <= IDLE;
                end
              end else r_tmr <= r_tmr + 20'd1;
            end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_ds2411_emulator.sv
// tb_ds2411_emulator: randomized 1-Wire master with an event scoreboard for the DS2411 emulator.
module tb_ds2411_emulator;
  logic        clk = 1'b0, rst_n = 1'b0, master_low = 1'b0;
  logic [63:0] rom_id = '0;
  logic        pd, busy, rom_done, cmd_err, dq;
  logic [7:0]  last_cmd;
  assign dq = ~(master_low | pd);
  always #5 clk = ~clk;

  ds2411_emulator #(.CLK_MHZ(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dq_in(dq), .o_dq_pd(pd), .i_rom_id(rom_id),
    .o_busy(busy), .o_rom_done(rom_done), .o_cmd_err(cmd_err), .o_last_cmd(last_cmd)
  );

  localparam int EV_PRES = 0, EV_ERR = 1, EV_DONE = 2;
  int          checks = 0, failures = 0, pd_run = 0, pd_cycles = 0;
  int          exp_kind[$];
  logic [63:0] exp_data[$];
  logic [63:0] rd_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [55:0] d);
    logic [7:0] c = '0;
    for (int i = 0; i < 56; i++) c = (c >> 1) ^ ((c[0] ^ d[i]) ? 8'h8C : 8'h00);
    return c;
  endfunction

  function automatic logic [63:0] model_rom(input logic [63:0] r);
`ifdef DS2411_CRC_GEN_EN
    return {crc8(r[55:0]), r[55:0]};
`else
    return r;
`endif
  endfunction

  function automatic logic rom_cmd(input logic [7:0] c);
    return c == 8'h33 || c == 8'h0F;
  endfunction

  task automatic expect_ev(input int kind, input string name, input logic [63:0] act);
    if (exp_kind.size() == 0 || exp_kind[0] != kind) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s: got event %0d with %h, scoreboard expected %0d", name, kind, act,
               exp_kind.size() ? exp_kind[0] : -1);
    end else begin
      void'(exp_kind.pop_front());
      check(name, act, exp_data.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (pd) begin
      pd_run++;
      pd_cycles++;
    end else if (pd_run > 0) begin
      if (pd_run >= 100) begin
        expect_ev(EV_PRES, "presence_width", 64'(pd_run));
        check("presence_busy", 64'(busy), 64'd1);
      end
      pd_run = 0;
    end
    if (rom_done) begin
      expect_ev(EV_DONE, "rom_read", rd_val);
      check("done_busy", 64'(busy), 64'd0);
    end
    if (cmd_err) begin
      expect_ev(EV_ERR, "last_cmd", 64'(last_cmd));
      check("err_busy", 64'(busy), 64'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_reset();
    int d = 0;
    master_low = 1'b1;
    cyc(500);
    exp_kind.push_back(EV_PRES);
    exp_data.push_back(64'd120);
    master_low = 1'b0;
    while (!pd && d < 80) begin cyc(1); d++; end
    checks++;
    if (d < 30 || d > 35) begin
      failures++;
      $display("FAIL presence_delay: got %0d cycles required 30..35", d);
    end
    d = 0;
    while (pd && d < 200) begin cyc(1); d++; end
    cyc(15);
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      master_low = 1'b1;
      cyc(b[i] ? 6 : 60);
      master_low = 1'b0;
      cyc(b[i] ? 64 : 10);
    end
  endtask

  task automatic read_rom(input int n);
    int low;
    rd_val = '0;
    for (int i = 0; i < n; i++) begin
      low = $urandom_range(3, 6);
      master_low = 1'b1;
      cyc(low);
      master_low = 1'b0;
      cyc(12 - low);
      rd_val[i] = dq;
      cyc(58);
    end
  endtask

  task automatic txn(input logic [63:0] rom, input logic [7:0] cmd, input logic change);
    int p;
    rom_id = rom;
    bus_reset();
    if (change) rom_id = {$urandom, $urandom};
    exp_kind.push_back(rom_cmd(cmd) ? EV_DONE : EV_ERR);
    exp_data.push_back(rom_cmd(cmd) ? model_rom(rom) : 64'(cmd));
    write_byte(cmd);
    p = pd_cycles;
    read_rom(64);
    if (!rom_cmd(cmd)) begin
      check("mute_pd_cycles", 64'(pd_cycles - p), 64'd0);
      check("mute_read", rd_val, '1);
    end
    cyc(20);
  endtask

  initial begin
    logic [7:0]  c;
    logic [63:0] r;
    int          w;
    cyc(3);
    check("rst_pd", 64'(pd), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(rom_done), 64'd0);
    check("rst_err", 64'(cmd_err), 64'd0);
    check("rst_last_cmd", 64'(last_cmd), 64'd0);
    rst_n = 1'b1;
    cyc(5);
    txn(64'hA200000001B81C02, 8'h33, 1'b0);
    txn(64'h0000000001B81C02, 8'h0F, 1'b0);
    txn({$urandom, $urandom}, 8'hCC, 1'b0);
    r = {$urandom, $urandom};
    rom_id = r;
    bus_reset();
    write_byte(8'h33);
    read_rom(20);
    check("abort_partial", 64'(rd_val[19:0]), 64'(model_rom(r) & 64'hFFFFF));
    txn(r, 8'h33, 1'b0);
    for (int k = 0; k < 3; k++) begin
      c = (k == 0) ? 8'h0F : 8'h33;
      if (k == 2) do c = 8'($urandom); while (rom_cmd(c));
      txn({$urandom, $urandom}, c, k == 1);
    end
    rom_id = {$urandom, $urandom} & ~64'd1;
    bus_reset();
    write_byte(8'h33);
    master_low = 1'b1;
    w = 0;
    while (!pd && w < 20) begin cyc(1); w++; end
    check("async_pd_before", 64'(pd), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_pd", 64'(pd), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_last_cmd", 64'(last_cmd), 64'd0);
    master_low = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(80);
    txn({$urandom, $urandom}, 8'h33, 1'b0);
    cyc(50);
    check("scoreboard_empty", 64'(exp_kind.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ds2411_emulator.md
Name: ds2411_emulator

Overview:
- 1-Wire slave that emulates a DS2411 silicon serial number on the single-wire DQ bus.
- Counterpart of the read_ds2411 bus master; gives that master a synthesizable target in simulation and on hardware.
- Answers master reset pulses with a presence pulse and receives the command byte.
- On Read ROM, returns a 64-bit ROM ID, LSB first, on master-initiated read slots.
- DQ is open-drain: the block only ever pulls low or releases.

Parameters:
- CLK_MHZ, 100, clk frequency in MHz; every timing constant below is multiplied by it to get cycles.
- RESET_US, 480, minimum master low time recognised as a reset pulse.
- PRES_DELAY_US, 30, delay from DQ rise after reset to start of presence pulse.
- PRES_US, 120, presence pulse width.
- SAMPLE_US, 30, time from slot falling edge to sampling of a master write bit.
- HOLD_US, 30, time DQ is held low for a transmitted 0 bit, measured from slot falling edge.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- dq_in  in  1  DQ bus level (pad input, asynchronous)
- dq_pd  out  1  1 = pull DQ low, 0 = release
- rom_id  in  64  ROM image; [7:0] family code, [55:8] serial, [63:56] CRC
- busy  out  1  high from presence start until ROM sent or command rejected
- rom_done  out  1  one-cycle pulse after the 64th bit slot
- cmd_err  out  1  one-cycle pulse when an unsupported command is received
- last_cmd  out  8  most recently received command byte

Behaviour:
- Reset (reset=0): state IDLE; dq_pd=0, busy=0, rom_done=0, cmd_err=0, last_cmd=8'h00; all counters 0.
- DQ synchronisation: dq_in passes through a 2-flop synchroniser. Edges come from the synced value, so all timing is relative to the synced edge (2-cycle latency).
- Own drive masking: falling edges and low time are ignored while dq_pd=1 or within 2 cycles of its release.
- Low-time counter: 20-bit, saturating; counts cycles DQ is low and clears on high.
- Reset recognition: reaching RESET_US*CLK_MHZ sets rst_seen in ANY state, aborting any transfer; dq_pd goes 0 immediately. The next rising edge enters PRES_WAIT.
- States:
  - IDLE: waits for rst_seen plus a rising edge.
  - PRES_WAIT: counts PRES_DELAY_US, then enters PRES_DRIVE; busy=1.
  - PRES_DRIVE: dq_pd=1 for PRES_US, then releases and enters CMD_RX with bit index 0.
  - CMD_RX: on each falling edge, start the slot timer; at SAMPLE_US, sample DQ into cmd[idx], LSB first. After 8 bits, last_cmd=cmd. Command 8'h33 or 8'h0F goes to ROM_TX with index 0; anything else pulses cmd_err and goes to MUTE.
  - ROM_TX: on each falling edge, if tx bit[idx]=0 then dq_pd=1 for HOLD_US cycles from that edge; bit 1 leaves DQ released. idx increments at the slot edge. After bit 63's hold window, pulse rom_done, busy=0, go IDLE.
  - MUTE: busy=0; ignores slots until the next reset pulse.
- A falling edge arriving while the slot timer is still running (a slot shorter than SAMPLE_US/HOLD_US) restarts the timer and counts as a new slot. The previous write bit is not sampled.
- A reset pulse during PRES_DRIVE or a 0-bit hold is measured only after release; the master low time is what counts.
- rom_id is captured into a shift register when PRES_DRIVE is entered; later changes take effect at the next reset.

Optional Feature:
- DS2411_CRC_GEN_EN defined: the block computes Dallas CRC-8 (x^8+x^5+x^4+1, LSB first, init 0) over the captured rom_id[55:0] and transmits it as byte 7; rom_id[63:56] is ignored.
- Not defined: rom_id is transmitted verbatim.

Decomposition:
- Shared package ds2411_pkg holds:
  - state encoding (IDLE, PRES_WAIT, PRES_DRIVE, CMD_RX, ROM_TX, MUTE)
  - command constants CMD_READ_ROM=8'h33, CMD_READ_ROM_LEGACY=8'h0F
  - CRC polynomial constant
- Sub-module onewire_crc8: bitwise serial CRC. The master's checker reuses it.

Test Plan:
- Master holds DQ low 500 us, then releases -> dq_pd rises about 30 us after the release, lasts 120 us, busy=1.
- Reset then command 0x33, then 64 read slots, rom_id=64'hA200000001B81C02 -> master reads 64'hA200000001B81C02, rom_done pulses once, busy=0.
- With DS2411_CRC_GEN_EN and rom_id=64'h0000000001B81C02 -> received byte 7 = 8'hA2.
- Command 0xCC -> cmd_err pulse, last_cmd=8'hCC, dq_pd stays 0 for the next 64 slots.
- Reset pulse issued after 20 of 64 ROM bits -> transfer aborts, new presence pulse, full ROM re-read correct from bit 0.
- reset asserted mid-ROM_TX while dq_pd=1 -> dq_pd=0 asynchronously, state IDLE, busy=0.
